hex_overlay_renderer: RTL
=========================

# hex_overlay_renderer

Pipelined text-overlay pixel stage between the VGA timing generator and the VGA pins. It renders the 11 debug registers plus the fetch-stage PC and IR as 13 rows of 4 hex digits. It snapshots all displayed values once per frame so the image is tear-free. Sync outputs are delayed to stay aligned with the colour outputs.

## Interface
Parameters:
- ORIGIN_X, 16, left pixel column of the text block
- ORIGIN_Y, 16, top pixel row of the text block
- H_ACTIVE, 640, visible width; x >= H_ACTIVE is blanking
- V_ACTIVE, 480, visible height; y >= V_ACTIVE is blanking

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous active-high reset
- x  in  11  current pixel column from timing generator
- y  in  11  current pixel row from timing generator
- hs_in  in  1  horizontal sync, active-low, aligned with x/y
- vs_in  in  1  vertical sync, active-low, aligned with x/y
- registerVGA  in  176  11 x 16-bit registers; reg k = bits [16k+15:16k]
- IfPC  in  16  fetch-stage PC
- IfIR  in  16  fetch-stage instruction
- hs  out  1  delayed hs_in
- vs  out  1  delayed vs_in
- r, g, b  out  3 each  pixel colour

## Operation
- Snapshot:
  - vs_in registered each cycle. On the falling edge (prev=1, now=0), all 208 bits (registerVGA, IfPC, IfIR) are captured into a snapshot register.
  - Values presented in the cycle where vs_in is first seen low are the ones captured.
  - Rendering uses only the snapshot.
- Layout:
  - Cell size is 8 wide x 16 tall.
  - Text region: ORIGIN_X <= x < ORIGIN_X+32 and ORIGIN_Y <= y < ORIGIN_Y+208.
  - Offsets: dx = x-ORIGIN_X, dy = y-ORIGIN_Y.
  - row = dy[7:4] (0..12), digit = dx[4:3] (0..3), grow = dy[3:0], gcol = dx[2:0].
  - Rows 0..10 show reg 0..10. Row 11 shows IfPC. Row 12 shows IfIR.
  - Digit 0 shows nibble [15:12]; digit 3 shows nibble [3:0].
- Glyph ROM:
  - Size is 16 digits x 16 rows x 8 bits. Bit 7 is the leftmost pixel.
  - Fixed entries: rows 0, 1, 14, 15 and bit 0 (gcol 7) are zero for every digit. Row 2 of 'F' = 8'h7E; row 2 of '0' = 8'h3C.
- Colour selection, first match wins:
  - Blanking (x >= H_ACTIVE or y >= V_ACTIVE): r=g=b=0.
  - Text region with glyph bit set: rows 0..10 white (7,7,7); rows 11..12 yellow (7,7,0).
  - Otherwise: background (0,0,2).
- Comparisons and subtractions use 11-bit unsigned arithmetic. Region tests precede any use of dx/dy, so negative offsets wrap harmlessly and never select a glyph.

## Timing
- Pipeline, one register per stage, no stalls, one pixel per clock:
  - S1: register x, y, hs_in, vs_in; compute blank, in_region, row, digit, grow, gcol.
  - S2: select nibble from snapshot; registered glyph ROM read; carry gcol and flags.
  - S3: bit select and colour mux into the output registers.
- Latency: r/g/b for input pixel (x,y) appear 3 cycles after x/y are presented. hs/vs pass through a matching 3-stage delay, so sync-to-pixel alignment is preserved exactly.
- Snapshot timing:
  - The snapshot updates at the clock edge after vs_in is sampled low.
  - Pixels already in flight read the snapshot at S2.
  - The snapshot changes only during vertical sync, so no visible pixel is affected.
- Reset, checked each cycle:
  - All pipeline stages and outputs clear.
  - Outputs: hs=1, vs=1, r=g=b=0.
  - Snapshot = 0, so digits render as '0'. Previous-vs register = 1.
- Reset mid-frame: outputs return to the reset values on the next edge. The first valid pixel appears 3 cycles after rst deasserts. The snapshot stays 0 until the next vs falling edge.
- If vs_in is held low, exactly one capture occurs; no recapture until vs_in returns high and then falls again.

## Test plan
- Reset: assert rst for 2 cycles mid-line. Expect hs=vs=1 and rgb=0 during reset. After release, pixel (16,18) renders row 2 of '0' (8'h3C), so bits 7,6 = BG and bit 5 = white at 3-cycle latency.
- Snapshot:
  - registerVGA[15:0]=16'hF000, drive vs falling edge, then x=16..23, y=18. Expect colours BG,W,W,W,W,W,W,BG, each 3 cycles after its input.
  - Change registerVGA to 16'h0000 mid-frame. The next frame's rendering is unchanged until the following vs falling edge.
- PC row: IfPC=16'hF000, captured, then x=17, y=16+176+2. Expect (7,7,0).
- Spacing and blanking:
  - gcol 7 in any text cell gives (0,0,2).
  - x=640, y=10 gives (0,0,0).
  - x=48 (outside region, active) gives (0,0,2).
  - y=ORIGIN_Y+208 gives BG.
- Sync alignment: drive a full 800x525 frame with hs_in/vs_in. Check hs/vs equal the inputs delayed by exactly 3 cycles at every edge.
- Held vs: hold vs_in low 2 lines while changing registerVGA every cycle. Exactly one capture occurs, with the value from the first low cycle.

Source files
------------

// File: rtl/hex_overlay_renderer.sv
`default_nettype none
// ============================================================================
// Module   : hex_overlay_renderer
// Function : 3-stage pixel pipeline that draws 13 rows x 4 hex digits of debug
//            state over the VGA stream, using a per-frame snapshot.
// Revision : 1.0  initial release
// ============================================================================
module hex_overlay_renderer #(
    parameter int ORIGIN_X = 16,
    parameter int ORIGIN_Y = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [10:0]  x,
    input  logic [10:0]  y,
    input  logic         hs_in,
    input  logic         vs_in,
    input  logic [175:0] registerVGA,
    input  logic [15:0]  IfPC,
    input  logic [15:0]  IfIR,
    output logic         hs,
    output logic         vs,
    output logic [2:0]   r,
    output logic [2:0]   g,
    output logic [2:0]   b
);

    localparam logic [10:0] c_xLo     = 11'(ORIGIN_X);
    localparam logic [10:0] c_xHi     = 11'(ORIGIN_X + 32);
    localparam logic [10:0] c_yLo     = 11'(ORIGIN_Y);
    localparam logic [10:0] c_yHi     = 11'(ORIGIN_Y + 208);
    localparam logic [10:0] c_hActive = 11'(H_ACTIVE);
    localparam logic [10:0] c_vActive = 11'(V_ACTIVE);

    // Glyph rows 2..13 packed MSB-first; rows 0,1,14,15 and gcol 7 stay blank.
    function automatic logic [7:0] glyphRow(input logic [3:0] nib, input logic [3:0] grow);
        logic [95:0] bmp;
        logic [3:0]  k;
        case (nib)
            4'h0: bmp = 96'h3C_66_66_6E_76_66_66_66_66_3C_00_00;
            4'h1: bmp = 96'h18_38_78_18_18_18_18_18_18_7E_00_00;
            4'h2: bmp = 96'h3C_66_06_0C_18_30_60_60_66_7E_00_00;
            4'h3: bmp = 96'h3C_66_06_06_1C_06_06_06_66_3C_00_00;
            4'h4: bmp = 96'h0C_1C_3C_6C_CC_FE_0C_0C_0C_1E_00_00;
            4'h5: bmp = 96'h7E_60_60_7C_06_06_06_06_66_3C_00_00;
            4'h6: bmp = 96'h3C_66_60_7C_66_66_66_66_66_3C_00_00;
            4'h7: bmp = 96'h7E_66_06_0C_18_18_18_18_18_18_00_00;
            4'h8: bmp = 96'h3C_66_66_66_3C_66_66_66_66_3C_00_00;
            4'h9: bmp = 96'h3C_66_66_66_3E_06_06_06_66_3C_00_00;
            4'hA: bmp = 96'h18_3C_66_66_66_7E_66_66_66_66_00_00;
            4'hB: bmp = 96'h7C_66_66_66_7C_66_66_66_66_7C_00_00;
            4'hC: bmp = 96'h3C_66_60_60_60_60_60_60_66_3C_00_00;
            4'hD: bmp = 96'h78_6C_66_66_66_66_66_66_6C_78_00_00;
            4'hE: bmp = 96'h7E_60_60_60_7C_60_60_60_60_7E_00_00;
            default: bmp = 96'h7E_60_60_60_7C_60_60_60_60_60_00_00;
        endcase
        k = 4'd13 - grow;
        if (grow < 4'd2 || grow > 4'd13) begin
            return 8'h00;
        end
        return bmp[{k, 3'b000} +: 8];
    endfunction

    // ---------------- snapshot ----------------
    logic [207:0] r_snapshot;

    // ---------------- stage 1 ----------------
    logic [4:0] w_dx;
    logic [7:0] w_dy;
    logic       w_blank;
    logic       w_inRegion;

    logic       r_s1Hs, r_s1Vs, r_s1Blank, r_s1InRegion;
    logic [3:0] r_s1Row, r_s1Grow;
    logic [1:0] r_s1Digit;
    logic [2:0] r_s1Gcol;

    // Only the low offset bits are consumed; they equal the low bits of the
    // full 11-bit subtraction, so narrowing changes nothing.
    assign w_dx       = x[4:0] - c_xLo[4:0];
    assign w_dy       = y[7:0] - c_yLo[7:0];
    assign w_blank    = (x >= c_hActive) || (y >= c_vActive);
    assign w_inRegion = (x >= c_xLo) && (x < c_xHi) && (y >= c_yLo) && (y < c_yHi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Hs       <= 1'b1;
            r_s1Vs       <= 1'b1;
            r_s1Blank    <= 1'b0;
            r_s1InRegion <= 1'b0;
            r_s1Row      <= 4'd0;
            r_s1Grow     <= 4'd0;
            r_s1Digit    <= 2'd0;
            r_s1Gcol     <= 3'd0;
            r_snapshot   <= '0;
        end else begin
            r_s1Hs       <= hs_in;
            r_s1Vs       <= vs_in;
            r_s1Blank    <= w_blank;
            r_s1InRegion <= w_inRegion;
            r_s1Row      <= w_dy[7:4];
            r_s1Grow     <= w_dy[3:0];
            r_s1Digit    <= w_dx[4:3];
            r_s1Gcol     <= w_dx[2:0];
            // r_s1Vs doubles as the previous-vs sample for edge detection.
            if (r_s1Vs && !vs_in) begin
                r_snapshot <= {IfIR, IfPC, registerVGA};
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic [15:0] w_word;
    logic [3:0]  w_nib;

    always_comb begin
        w_word = 16'h0000;
        for (int k = 0; k < 13; k++) begin
            if (r_s1Row == 4'(k)) begin
                w_word = r_snapshot[16*k +: 16];
            end
        end
        case (r_s1Digit)
            2'd0:    w_nib = w_word[15:12];
            2'd1:    w_nib = w_word[11:8];
            2'd2:    w_nib = w_word[7:4];
            default: w_nib = w_word[3:0];
        endcase
    end

    logic       r_s2Hs, r_s2Vs, r_s2Blank, r_s2InRegion, r_s2Yellow;
    logic [7:0] r_s2Glyph;
    logic [2:0] r_s2Gcol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Hs       <= 1'b1;
            r_s2Vs       <= 1'b1;
            r_s2Blank    <= 1'b0;
            r_s2InRegion <= 1'b0;
            r_s2Yellow   <= 1'b0;
            r_s2Glyph    <= 8'h00;
            r_s2Gcol     <= 3'd0;
        end else begin
            r_s2Hs       <= r_s1Hs;
            r_s2Vs       <= r_s1Vs;
            r_s2Blank    <= r_s1Blank;
            r_s2InRegion <= r_s1InRegion;
            r_s2Yellow   <= (r_s1Row >= 4'd11);
            r_s2Glyph    <= glyphRow(w_nib, r_s1Grow);
            r_s2Gcol     <= r_s1Gcol;
        end
    end

    // ---------------- stage 3 ----------------
    logic       w_bit;
    logic       r_hs, r_vs;
    logic [2:0] r_r, r_g, r_b;

    assign w_bit = r_s2Glyph[3'd7 - r_s2Gcol];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_r  <= 3'd0;
            r_g  <= 3'd0;
            r_b  <= 3'd0;
        end else begin
            r_hs <= r_s2Hs;
            r_vs <= r_s2Vs;
            if (r_s2Blank) begin
                r_r <= 3'd0;
                r_g <= 3'd0;
                r_b <= 3'd0;
            end else if (r_s2InRegion && w_bit) begin
                r_r <= 3'd7;
                r_g <= 3'd7;
                r_b <= r_s2Yellow ? 3'd0 : 3'd7;
            end else begin
                r_r <= 3'd0;
                r_g <= 3'd0;
                r_b <= 3'd2;
            end
        end
    end

    assign hs = r_hs;
    assign vs = r_vs;
    assign r  = r_r;
    assign g  = r_g;
    assign b  = r_b;

endmodule
`default_nettype wire
